// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator and its detector partner.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int unsigned PAT_LEN = 6;
    localparam logic [PAT_LEN-1:0] PAT_A = 6'b111000;
    localparam logic [PAT_LEN-1:0] PAT_B = 6'b101110;

    // Bits needed to hold a length in the range 0..max_len.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_gen_fifo.sv
// Two-entry synchronous FIFO with registered full/empty flags.
module seq_gen_fifo #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data_c,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nx;
    logic         do_push;
    logic         do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        case ({do_push, do_pop})
            2'b10:   count_nx = count + 2'd1;
            2'b01:   count_nx = count - 2'd1;
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count_nx;
            full  <= (count_nx == 2'd2);
            empty <= (count_nx == 2'd0);
        end
    end

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: queues {len, data} frames and shifts them out MSB-first
// on dout/dout_vld, inserting GAP idle cycles after each frame.
module seq_generator
    import seq_gen_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = len_width(MAX_LEN),
    parameter int unsigned GAP     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic [MAX_LEN-1:0] req_data,
    input  logic [LEN_W-1:0]   req_len,
    input  logic               tx_en,
    output logic               dout_vld,
    output logic               dout,
    output logic               frame_done,
    output logic               busy
);

    localparam int unsigned ENTRY_W = LEN_W + MAX_LEN;
    localparam int unsigned GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t               state;
    state_t               state_nx;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_c;
    logic [ENTRY_W-1:0]   head_c;
    logic [LEN_W-1:0]     head_len;
    logic [MAX_LEN-1:0]   head_data;
    logic [LEN_W-1:0]     len_clamp;
    logic [MAX_LEN-1:0]   shreg;
    logic [MAX_LEN-1:0]   shreg_nx;
    logic [LEN_W-1:0]     bitcnt;
    logic [LEN_W-1:0]     bitcnt_nx;
    logic [GAP_W-1:0]     gap_cnt;
    logic [GAP_W-1:0]     gap_cnt_nx;
    logic                 dout_nx;
    logic                 dout_vld_nx;
    logic                 frame_done_nx;

    seq_gen_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_vld && !fifo_full),
        .wr_data   ({req_len, req_data}),
        .pop       (pop_c),
        .rd_data_c (head_c),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign req_rdy = !fifo_full;
    assign busy    = !fifo_empty || (state != ST_IDLE);

    assign {head_len, head_data} = head_c;
    assign len_clamp = (head_len > MAX_LEN_L) ? MAX_LEN_L : head_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Zero-length frames are popped and discarded without leaving IDLE.
    always_comb begin
        state_nx = state;
        pop_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c = 1'b1;
                    if (len_clamp != '0) state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tx_en && (bitcnt == LEN_W'(1))) state_nx = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_nx      = shreg;
        bitcnt_nx     = bitcnt;
        gap_cnt_nx    = gap_cnt;
        dout_nx       = dout;
        dout_vld_nx   = 1'b0;
        frame_done_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                gap_cnt_nx = '0;
                if (!fifo_empty && (len_clamp != '0)) begin
                    shreg_nx  = head_data << (MAX_LEN_L - len_clamp);
                    bitcnt_nx = len_clamp;
                end
            end
            ST_SHIFT: begin
                gap_cnt_nx = '0;
                if (tx_en) begin
                    dout_nx       = shreg[MAX_LEN-1];
                    dout_vld_nx   = 1'b1;
                    shreg_nx      = {shreg[MAX_LEN-2:0], 1'b0};
                    bitcnt_nx     = bitcnt - LEN_W'(1);
                    frame_done_nx = (bitcnt == LEN_W'(1));
                end
            end
            ST_GAP: begin
                gap_cnt_nx = gap_cnt + GAP_W'(1);
            end
            default: begin
                gap_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bitcnt     <= '0;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            dout_vld   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            shreg      <= shreg_nx;
            bitcnt     <= bitcnt_nx;
            gap_cnt    <= gap_cnt_nx;
            dout       <= dout_nx;
            dout_vld   <= dout_vld_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule
